// File: rtl/mmio_bus_arbiter.sv
// Two-requester MMIO arbiter: round-robin grant onto one shared device bus,
// one-cycle ack per access, and an error ack when the device never answers.
module mmio_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              o_dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

    state_t            r_state;
    logic              r_owner;
    logic              r_last;
    logic [7:0]        r_cnt;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_err;
    logic [DATA_W-1:0] r_rsp;
    logic              r_bus_valid;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;

    logic w_pick1;
    logic w_in_ack;

    // On a tie the requester that was not served last wins.
    assign w_pick1  = req1 & (~req0 | ~r_last);
    // Requests seen during the ack cycle are not arbitrated until the next IDLE cycle.
    assign w_in_ack = r_ack0 | r_ack1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_cnt       <= 8'd0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_err       <= 1'b0;
            r_rsp       <= '0;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err  <= 1'b0;
            r_rsp  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if ((req0 | req1) && !w_in_ack) begin
                        r_owner     <= w_pick1;
                        r_bus_we    <= w_pick1 ? we1 : we0;
                        r_bus_addr  <= w_pick1 ? addr1 : addr0;
                        r_bus_wdata <= w_pick1 ? wdata1 : wdata0;
                        r_bus_valid <= 1'b1;
                        r_cnt       <= 8'd0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A ready in the same cycle as the timeout still completes normally.
                    if (bus_ready) begin
                        r_ack0      <= ~r_owner;
                        r_ack1      <= r_owner;
                        r_rsp       <= r_bus_we ? '0 : bus_rdata;
                        r_last      <= r_owner;
                        r_bus_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (r_cnt == TO_VAL) begin
                        r_ack0      <= ~r_owner;
                        r_ack1      <= r_owner;
                        r_err       <= 1'b1;
                        r_last      <= r_owner;
                        r_bus_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign err         = r_err;
    assign rsp_rdata   = r_rsp;
    assign bus_valid   = r_bus_valid;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign o_dbg_state = (r_state == ST_BUSY);

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: directed table, round-robin and reset sequences,
// then random accesses predicted by a transaction-level model.
module tb_mmio_bus_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err;
    logic [31:0] rsp_rdata;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        o_dbg_state;

    int total;
    int bad;
    bit m_last;

    mmio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err(err), .rsp_rdata(rsp_rdata),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .o_dbg_state(o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    // lat = number of BUSY cycles with bus_ready low before ready is raised.
    typedef struct {
        bit          r0, r1, we0, we1;
        logic [31:0] a0, a1, d0, d1;
        int          lat;
        logic [31:0] rdata;
        bit          perturb;
        bit          e_own, e_err;
        logic [31:0] e_rsp;
        int          e_vc;
        bit          e_we;
        logic [31:0] e_addr, e_wdata;
    } txn_t;

    txn_t tbl[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // The counter reads TIMEOUT in the (TIMEOUT+1)th BUSY cycle, so that is
    // the last cycle in which ready still completes the access normally.
    function automatic txn_t predict(input txn_t t);
        txn_t r;
        r = t;
        if (t.r0 && t.r1) r.e_own = ~m_last;
        else              r.e_own = t.r1;
        r.e_we    = r.e_own ? t.we1 : t.we0;
        r.e_addr  = r.e_own ? t.a1 : t.a0;
        r.e_wdata = r.e_own ? t.d1 : t.d0;
        if (t.lat <= TIMEOUT) begin
            r.e_err = 1'b0;
            r.e_vc  = t.lat + 1;
            r.e_rsp = r.e_we ? 32'd0 : t.rdata;
        end else begin
            r.e_err = 1'b1;
            r.e_vc  = TIMEOUT + 1;
            r.e_rsp = 32'd0;
        end
        return r;
    endfunction

    task automatic do_txn(input txn_t t);
        int  k;
        int  guard;
        bit  seen;
        req0 = t.r0; req1 = t.r1; we0 = t.we0; we1 = t.we1;
        addr0 = t.a0; addr1 = t.a1; wdata0 = t.d0; wdata1 = t.d1;
        bus_ready = 1'b0;
        k = 0; guard = 0; seen = 1'b0;
        while (!seen && guard < 300) begin
            @(negedge clk);
            guard++;
            if (ack0 | ack1) begin
                seen = 1'b1;
                check("ack_owner", 128'({ack1, ack0}), 128'(t.e_own ? 2'b10 : 2'b01));
                check("ack_err", 128'(err), 128'(t.e_err));
                check("ack_rdata", 128'(rsp_rdata), 128'(t.e_rsp));
                check("ack_valid_low", 128'(bus_valid), 128'(0));
                check("busy_cycles", 128'(k), 128'(t.e_vc));
            end else if (bus_valid) begin
                if (k == 0) check("grant_latency", 128'(guard), 128'(1));
                check("bus_cmd", 128'({bus_we, bus_addr, bus_wdata}),
                      128'({t.e_we, t.e_addr, t.e_wdata}));
                check("busy_quiet", 128'({err, rsp_rdata}), 128'(0));
                if (k == 0 && t.perturb) begin
                    if (t.e_own) req1 = 1'b0; else req0 = 1'b0;
                    addr0 = ~addr0; addr1 = ~addr1; we0 = ~we0; we1 = ~we1;
                    wdata0 = ~wdata0; wdata1 = ~wdata1;
                end
                bus_ready = (k == t.lat);
                bus_rdata = (k == t.lat) ? t.rdata : $urandom;
                k++;
            end
        end
        if (!seen) check("ack_timeout", 128'(0), 128'(1));
        req0 = 1'b0; req1 = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        check("ack_pulse_end", 128'({ack0, ack1, err, rsp_rdata}), 128'(0));
        m_last = t.e_own;
    endtask

    initial begin
        txn_t t;
        int   n;
        int   cyc[4];
        bit   who[4];
        bit   first;
        int   pat;

        total = 0; bad = 0; m_last = 1'b1;
        rst = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        bus_ready = 0; bus_rdata = 0;

        //           r0 r1 we0 we1 a0     a1     d0            d1            lat rdata         pt own err rsp          vc  we addr   wdata
        tbl[0] = '{1, 0, 0, 0, 32'h10, 32'h0,  32'h0,        32'h0,        2,  32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 3,  0, 32'h10, 32'h0};
        tbl[1] = '{0, 1, 0, 1, 32'h0,  32'h20, 32'h0,        32'h5,        99, 32'h0BADF00D, 0, 1, 1, 32'h0,        16, 1, 32'h20, 32'h5};
        tbl[2] = '{1, 1, 0, 0, 32'h30, 32'h40, 32'h1,        32'h2,        15, 32'h12345678, 0, 0, 0, 32'h12345678, 16, 0, 32'h30, 32'h1};
        tbl[3] = '{1, 1, 1, 0, 32'h50, 32'h60, 32'hAA,       32'hBB,       0,  32'hCAFEF00D, 0, 1, 0, 32'hCAFEF00D, 1,  0, 32'h60, 32'hBB};
        tbl[4] = '{1, 1, 1, 1, 32'h70, 32'h80, 32'h11223344, 32'h55667788, 1,  32'hFFFFFFFF, 0, 0, 0, 32'h0,        2,  1, 32'h70, 32'h11223344};
        tbl[5] = '{0, 1, 0, 0, 32'h0,  32'h90, 32'h0,        32'h9,        16, 32'h77777777, 1, 1, 1, 32'h0,        16, 0, 32'h90, 32'h9};
        tbl[6] = '{1, 0, 1, 0, 32'hA0, 32'h0,  32'h42,       32'h0,        14, 32'h99,       1, 0, 0, 32'h0,        15, 1, 32'hA0, 32'h42};

        repeat (2) @(negedge clk);
        check("reset_ctrl", 128'({ack0, ack1, err, bus_valid, bus_we, o_dbg_state}), 128'(0));
        check("reset_data", 128'({rsp_rdata, bus_addr, bus_wdata}), 128'(0));
        rst = 1'b1;

        for (int i = 0; i < 7; i++) do_txn(tbl[i]);

        // Both requesters held through their acks: alternate grants, 3-cycle period.
        first = ~m_last;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h100; addr1 = 32'h200;
        bus_ready = 1; bus_rdata = 32'h5A5A5A5A;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (ack0 | ack1) begin
                check("rr_one_hot", 128'(ack0 & ack1), 128'(0));
                who[n] = ack1;
                cyc[n] = c;
                n++;
            end
        end
        req0 = 0; req1 = 0; bus_ready = 0;
        check("rr_count", 128'(n), 128'(4));
        if (n == 4) begin
            for (int i = 0; i < 4; i++) check("rr_order", 128'(who[i]), 128'(first ^ i[0]));
            for (int i = 1; i < 4; i++) check("rr_period", 128'(cyc[i] - cyc[i-1]), 128'(3));
        end
        m_last = first ^ 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a BUSY access.
        t = '{1, 0, 0, 0, 32'hB0, 32'h0, 32'h0, 32'h0, 0, 32'h31, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0};
        t = predict(t);
        do_txn(t);
        req0 = 1; we0 = 0; addr0 = 32'h1234;
        @(negedge clk);
        check("pre_reset_busy", 128'({bus_valid, o_dbg_state}), 128'(2'b11));
        #2 rst = 1'b0;
        #1;
        check("async_reset_ctrl", 128'({ack0, ack1, err, bus_valid, bus_we, o_dbg_state}), 128'(0));
        check("async_reset_data", 128'({rsp_rdata, bus_addr, bus_wdata}), 128'(0));
        req0 = 0;
        repeat (3) begin
            @(negedge clk);
            check("reset_no_ack", 128'({ack0, ack1, bus_valid}), 128'(0));
        end
        rst = 1'b1;
        m_last = 1'b1;
        t = '{1, 1, 0, 1, 32'hC0, 32'hD0, 32'h0, 32'h6, 3, 32'h4444, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0};
        t = predict(t);
        do_txn(t);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pat = $urandom_range(1, 3);
            t.r0 = (pat != 2); t.r1 = (pat != 1);
            t.we0 = 1'($urandom_range(0, 1)); t.we1 = 1'($urandom_range(0, 1));
            t.a0 = $urandom; t.a1 = $urandom; t.d0 = $urandom; t.d1 = $urandom;
            t.lat = $urandom_range(0, TIMEOUT + 3);
            t.rdata = $urandom;
            t.perturb = 1'($urandom_range(0, 1));
            t = predict(t);
            do_txn(t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
